// File: rtl/d_ff_pipe_en_if.sv
// Bundles the data/valid/control signals of the d_ff_pipe_en delay line.
// When the STALL_CNT_EN macro is defined, the bundle also carries stall_cnt.
interface d_ff_pipe_en_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_vld;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic [OCC_W-1:0] occ;
`ifdef STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    modport master (
        output en, flush, d, d_vld,
`ifdef STALL_CNT_EN
        input  stall_cnt,
`endif
        input  q, q_vld, occ
    );

    modport slave (
        input  en, flush, d, d_vld,
`ifdef STALL_CNT_EN
        output stall_cnt,
`endif
        output q, q_vld, occ
    );
endinterface

// File: rtl/d_ff_pipe_en.sv
// WIDTH x DEPTH enabled delay line with per-stage valid, synchronous flush and occupancy count.
// Defining STALL_CNT_EN adds a saturating 16-bit count of stalled edges while occupied.
module d_ff_pipe_en #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    d_ff_pipe_en_if.slave   bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Flush shares the reset clear path; it only differs in leaving the stall counter alone.
    logic clear;
    assign clear = !rst_n || bus.flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] data_q;
            logic             vld_q;
            logic [WIDTH-1:0] data_in;
            logic             vld_in;

            if (gi == 0) begin : g_head
                assign data_in = bus.d;
                assign vld_in  = bus.d_vld;
            end else begin : g_tail
                assign data_in = g_stage[gi-1].data_q;
                assign vld_in  = g_stage[gi-1].vld_q;
            end

            always_ff @(posedge clk) begin
                if (clear) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else if (bus.en) begin
                    data_q <= data_in;
                    vld_q  <= vld_in;
                end
            end
        end
    endgenerate

    logic             vld_last;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    assign vld_last = g_stage[DEPTH-1].vld_q;

    always_comb begin
        occ_d = occ_q;
        if (clear) begin
            occ_d = '0;
        end else if (bus.en) begin
            occ_d = occ_q + OCC_W'(bus.d_vld) - OCC_W'(vld_last);
        end
    end

    always_ff @(posedge clk) begin
        occ_q <= occ_d;
    end

    assign bus.q     = g_stage[DEPTH-1].data_q;
    assign bus.q_vld = vld_last;
    assign bus.occ   = occ_q;

`ifdef STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!rst_n) begin
            stall_d = '0;
        end else if (!bus.flush && !bus.en && (occ_q != '0) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        stall_q <= stall_d;
    end

    assign bus.stall_cnt = stall_q;
`endif
endmodule
